// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults, counter encodings and entry layout for the branch target buffer.
package bp_pkg;

    localparam int BP_PC_W    = 12;
    localparam int BP_ENTRIES = 32;
    localparam int BP_CTR_W   = 2;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_PC_W - BP_IDX_W;

    localparam logic [BP_CTR_W-1:0] CTR_WEAK_NT = BP_CTR_W'((1 << (BP_CTR_W - 1)) - 1);
    localparam logic [BP_CTR_W-1:0] CTR_WEAK_T  = BP_CTR_W'(1 << (BP_CTR_W - 1));

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_CTR_W-1:0] ctr;
        logic [BP_PC_W-1:0]  target;
    } bp_entry_t;

endpackage

// File: rtl/bp_btb_2bit_if.sv
// rtl/bp_btb_2bit_if.sv - fetch lookup / execute resolve bundle; BP_GSHARE_EN adds the history ports.
interface bp_btb_2bit_if #(
    parameter int PC_W  = 12,
    parameter int IDX_W = 5
);
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_next_pc;
    logic             resolve_valid;
    logic [PC_W-1:0]  resolve_pc;
    logic             resolve_taken;
    logic [PC_W-1:0]  resolve_target;
    logic [15:0]      hit_count;
`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] pred_ghr;
    logic [IDX_W-1:0] resolve_ghr;

    modport master (
        output fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target, resolve_ghr,
        input  pred_hit, pred_taken, pred_next_pc, hit_count, pred_ghr
    );
    modport slave (
        input  fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target, resolve_ghr,
        output pred_hit, pred_taken, pred_next_pc, hit_count, pred_ghr
    );
`else
    modport master (
        output fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
        input  pred_hit, pred_taken, pred_next_pc, hit_count
    );
    modport slave (
        input  fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
        output pred_hit, pred_taken, pred_next_pc, hit_count
    );
`endif
endinterface

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - combinational saturating up/down step of a direction counter.
module bp_sat_ctr #(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr,
    input  logic         up,
    output logic [W-1:0] next
);
    always_comb begin
        next = ctr;
        if (up) begin
            if (ctr != {W{1'b1}}) next = ctr + W'(1);
        end else begin
            if (ctr != '0) next = ctr - W'(1);
        end
    end
endmodule

// File: rtl/bp_btb_2bit.sv
// rtl/bp_btb_2bit.sv - direct-mapped BTB with saturating direction counters; BP_GSHARE_EN selects gshare indexing.
module bp_btb_2bit
    import bp_pkg::*;
#(
    parameter int PC_W    = BP_PC_W,
    parameter int ENTRIES = BP_ENTRIES,
    parameter int CTR_W   = BP_CTR_W,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = PC_W - IDX_W
) (
    input  logic          clock,
    input  logic          clear,
    bp_btb_2bit_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [CTR_W-1:0] ctr;
        logic [PC_W-1:0]  target;
    } entry_t;

    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(1 << (CTR_W - 1));

    entry_t           entries_q [ENTRIES];
    logic [15:0]      hit_count_q;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    entry_t           rd_e;
    entry_t           wr_e;
    logic             rd_hit;
    logic             wr_hit;
    logic [CTR_W-1:0] ctr_next;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    assign rd_idx       = bus.fetch_pc[IDX_W-1:0] ^ ghr;
    assign wr_idx       = bus.resolve_pc[IDX_W-1:0] ^ bus.resolve_ghr;
    assign bus.pred_ghr = ghr;

    // Truncating the concatenation keeps the shift legal even when IDX_W is 1.
    always_ff @(posedge clock) begin
        if (clear) begin
            ghr <= '0;
        end else if (bus.resolve_valid) begin
            ghr <= IDX_W'({ghr, bus.resolve_taken});
        end
    end
`else
    assign rd_idx = bus.fetch_pc[IDX_W-1:0];
    assign wr_idx = bus.resolve_pc[IDX_W-1:0];
`endif

    assign rd_tag = bus.fetch_pc[PC_W-1:IDX_W];
    assign wr_tag = bus.resolve_pc[PC_W-1:IDX_W];
    assign rd_e   = entries_q[rd_idx];
    assign wr_e   = entries_q[wr_idx];
    assign rd_hit = rd_e.valid && (rd_e.tag == rd_tag);
    assign wr_hit = wr_e.valid && (wr_e.tag == wr_tag);

    assign bus.pred_hit     = rd_hit;
    assign bus.pred_taken   = rd_hit && rd_e.ctr[CTR_W-1];
    assign bus.pred_next_pc = bus.pred_taken ? rd_e.target : bus.fetch_pc + PC_W'(1);
    assign bus.hit_count    = hit_count_q;

    bp_sat_ctr #(.W(CTR_W)) u_sat_ctr (
        .ctr  (wr_e.ctr),
        .up   (bus.resolve_taken),
        .next (ctr_next)
    );

    // Reads above see the pre-edge table; a same-cycle resolve becomes visible next cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, ctr: WEAK_NT, target: '0};
            end
            hit_count_q <= '0;
        end else begin
            if (rd_hit && (hit_count_q != 16'hFFFF)) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            if (bus.resolve_valid) begin
                if (wr_hit) begin
                    entries_q[wr_idx].ctr <= ctr_next;
                    if (bus.resolve_taken) begin
                        entries_q[wr_idx].target <= bus.resolve_target;
                    end
                end else if (bus.resolve_taken) begin
                    entries_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, ctr: WEAK_T,
                                           target: bus.resolve_target};
                end
            end
        end
    end
endmodule

// File: tb/tb_bp_btb_2bit.sv
// tb/tb_bp_btb_2bit.sv - directed and randomized checks of bp_btb_2bit against a table model.
module tb_bp_btb_2bit;
    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    bp_btb_2bit_if #(.PC_W(12), .IDX_W(5)) bus ();

    bp_btb_2bit dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit m_valid [32];
    int m_tag   [32];
    int m_ctr   [32];
    int m_tgt   [32];
    int m_hc;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 0;
        end
        m_hc = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int fpc, input bit rv, input int rpc, input bit rt,
                        input int rtgt, input bit clr);
        int fi, ri, mn;
        bit mh, mt, rh;
        clear              = clr;
        bus.fetch_pc       = 12'(fpc);
        bus.resolve_valid  = rv;
        bus.resolve_pc     = 12'(rpc);
        bus.resolve_taken  = rt;
        bus.resolve_target = 12'(rtgt);
`ifdef BP_GSHARE_EN
        bus.resolve_ghr    = '0;
`endif
        #2;
        fi = fpc % 32;
        mh = m_valid[fi] && (m_tag[fi] == fpc / 32);
        mt = mh && (m_ctr[fi] >= 2);
        mn = mt ? m_tgt[fi] : (fpc + 1) % 4096;
        chk("pred_hit", 32'(bus.pred_hit), 32'(mh));
        chk("pred_taken", 32'(bus.pred_taken), 32'(mt));
        chk("pred_next_pc", 32'(bus.pred_next_pc), 32'(mn));
        chk("hit_count", 32'(bus.hit_count), 32'(m_hc));
        @(posedge clock);
        if (clr) begin
            m_reset();
        end else begin
            if (mh && m_hc < 65535) m_hc++;
            if (rv) begin
                ri = rpc % 32;
                rh = m_valid[ri] && (m_tag[ri] == rpc / 32);
                if (rh) begin
                    if (rt) begin
                        m_ctr[ri] = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
                        m_tgt[ri] = rtgt;
                    end else begin
                        m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
                    end
                end else if (rt) begin
                    m_valid[ri] = 1'b1;
                    m_tag[ri]   = rpc / 32;
                    m_tgt[ri]   = rtgt;
                    m_ctr[ri]   = 2;
                end
            end
        end
        #1;
    endtask

    int pool [8] = '{'h010, 'h030, 'h3A0, 'hFFF, 'h01F, 'h7E5, 'h005, 'h0A5};

    initial begin
        clear              = 1'b1;
        bus.fetch_pc       = '0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_pc     = '0;
        bus.resolve_taken  = 1'b0;
        bus.resolve_target = '0;
`ifdef BP_GSHARE_EN
        bus.resolve_ghr    = '0;
`endif
        repeat (2) @(posedge clock);
        #1;
        m_reset();

        // post-reset lookup, then allocate with a same-cycle fetch that must still miss
        step('h010, 0, 0, 0, 0, 0);
        step('h010, 1, 'h010, 1, 'h3A0, 0);
        step('h010, 0, 0, 0, 0, 0);
        chk("alloc_next_pc_const", 32'(bus.pred_next_pc), 32'h3A0);

        // alias on the same index with a different tag
        step('h030, 0, 0, 0, 0, 0);
        step('h030, 1, 'h030, 1, 'h155, 0);
        step('h010, 0, 0, 0, 0, 0);
        step('h030, 0, 0, 0, 0, 0);

        // saturation up then down
        for (int i = 0; i < 5; i++) step('h010, 1, 'h010, 1, 'h3A0, 0);
        step('h010, 1, 'h010, 0, 0, 0);
        step('h010, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step('h010, 1, 'h010, 0, 0, 0);
        step('h010, 0, 0, 0, 0, 0);
        chk("sat_low_next_pc_const", 32'(bus.pred_next_pc), 32'h011);

        // wrap and clear priority
        step('hFFF, 0, 0, 0, 0, 0);
        step('h010, 1, 'h030, 1, 'h222, 1);
        step('h030, 0, 0, 0, 0, 0);
        step('h010, 0, 0, 0, 0, 0);

        for (int n = 0; n < 800; n++) begin
            step(pool[$urandom_range(7)], $urandom_range(1), pool[$urandom_range(7)],
                 $urandom_range(1), int'($urandom_range(4095)), $urandom_range(63) == 0);
        end

        // hit_count saturation
        step('h010, 1, 'h010, 1, 'h3A0, 0);
        bus.fetch_pc      = 12'h010;
        bus.resolve_valid = 1'b0;
        repeat (65540) @(posedge clock);
        m_hc = 65535;
        #1;
        step('h010, 0, 0, 0, 0, 0);
        step('h010, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
